// File: rtl/counter_arbiter.sv
// counter_arbiter
//   Round-robin owner of a single external load/enable counter shared by two
//   requesters. A winner's start/end operands are latched in IDLE; the block
//   then loads the counter with start (LOAD), enables it until it reads end
//   (COUNT) and signals completion (DONE). At least one IDLE cycle separates
//   operations so every request is arbitrated afresh.
//
//   Optional feature (macro COUNTER_ARBITER_ABORT_EN): dropping the granted
//   request during LOAD or COUNT abandons the operation without a done pulse.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high
//   req0/req1      requests for the counter
//   start0/end0    requester 0 load value / terminal value
//   start1/end1    requester 1 load value / terminal value
//   gnt0/gnt1      one-hot ownership, LOAD through DONE
//   done0/done1    one-cycle completion pulse for the owner
//   busy           state is not IDLE
//   cnt_load       load strobe to the shared counter
//   cnt_enable     count enable to the shared counter
//   cnt_freshdata  load value (zero outside LOAD)
//   cnt_q          current shared counter value
module counter_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] start0,
    input  logic [WIDTH-1:0] end0,
    input  logic [WIDTH-1:0] start1,
    input  logic [WIDTH-1:0] end1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             cnt_load,
    output logic             cnt_enable,
    output logic [WIDTH-1:0] cnt_freshdata,
    input  logic [WIDTH-1:0] cnt_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic             last_q, last_n;     // requester served most recently
    logic             owner_q, owner_n;   // requester currently granted
    logic [WIDTH-1:0] start_q, start_n;
    logic [WIDTH-1:0] end_q, end_n;
    logic             win;
    logic             at_end;

`ifdef COUNTER_ARBITER_ABORT_EN
    logic             req_own;
    assign req_own = owner_q ? req1 : req0;
`endif

    assign at_end = (cnt_q == end_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            last_q  <= 1'b1;   // requester 0 gets first priority
            owner_q <= 1'b0;
            start_q <= '0;
            end_q   <= '0;
        end else begin
            state   <= state_n;
            last_q  <= last_n;
            owner_q <= owner_n;
            start_q <= start_n;
            end_q   <= end_n;
        end
    end

    always_comb begin
        state_n       = state;
        last_n        = last_q;
        owner_n       = owner_q;
        start_n       = start_q;
        end_n         = end_q;
        win           = 1'b0;
        done0         = 1'b0;
        done1         = 1'b0;
        cnt_load      = 1'b0;
        cnt_enable    = 1'b0;
        cnt_freshdata = '0;

        busy = (state != IDLE);
        // owner_q is held stale in IDLE, so qualify grants with busy
        gnt0 = busy & ~owner_q;
        gnt1 = busy &  owner_q;

        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    // on a tie the requester not served last wins
                    win     = (req0 & req1) ? ~last_q : req1;
                    owner_n = win;
                    start_n = win ? start1 : start0;
                    end_n   = win ? end1   : end0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                cnt_load      = 1'b1;
                cnt_freshdata = start_q;
                state_n       = COUNT;
`ifdef COUNTER_ARBITER_ABORT_EN
                if (!req_own) begin
                    state_n = IDLE;
                    last_n  = owner_q;
                end
`endif
            end
            COUNT: begin
                // equality also covers start == end (zero enabled cycles)
                // and wrap-around through 2^WIDTH-1
                cnt_enable = ~at_end;
                if (at_end) state_n = DONE;
`ifdef COUNTER_ARBITER_ABORT_EN
                if (!req_own) begin
                    cnt_enable = 1'b0;
                    state_n    = IDLE;
                    last_n     = owner_q;
                end
`endif
            end
            DONE: begin
                done0   = ~owner_q;
                done1   =  owner_q;
                last_n  = owner_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the width of the shared counter value and of all start/end operands.
REQ-002 The block SHALL have port clock, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have ports req0 and req1, input, 1 each, requests for use of the shared counter.
REQ-005 The block SHALL have ports start0, end0, start1 and end1, input, WIDTH each, giving each requester's load value and terminal value.
REQ-006 The block SHALL have ports gnt0 and gnt1, output, 1 each, the one-hot ownership grant.
REQ-007 The block SHALL have ports done0 and done1, output, 1 each, one-cycle completion pulses.
REQ-008 The block SHALL have port busy, output, 1, asserted whenever the state is not IDLE.
REQ-009 The block SHALL have ports cnt_load, cnt_enable, output, 1 each, and cnt_freshdata, output, WIDTH, which drive the shared load/enable counter.
REQ-010 The block SHALL have port cnt_q, input, WIDTH, the current value of the shared counter.

Function
REQ-011 The block SHALL implement four states: IDLE, LOAD, COUNT and DONE.
REQ-012 In IDLE, requests SHALL be sampled; with any request present, the block SHALL latch the winner's start/end values, set the corresponding grant, and go to LOAD on the next edge.
REQ-013 Arbitration SHALL be round-robin: on simultaneous req0 and req1, the requester not served last wins; after reset, requester 0 has priority.
REQ-014 In LOAD, cnt_load SHALL be 1 and cnt_freshdata SHALL equal the latched start value for exactly one cycle, and the next state SHALL be COUNT.
REQ-015 In COUNT, cnt_enable SHALL be 1 combinationally while cnt_q != latched end and 0 when cnt_q == latched end; equality SHALL move the state to DONE.
REQ-016 Wrap-around: when end < start, counting SHALL continue through 2^WIDTH-1 to 0, giving (end - start) mod 2^WIDTH enabled cycles.
REQ-017 When start == end, COUNT SHALL last one cycle with zero enabled cycles.
REQ-018 In DONE, done0 or done1 (whichever matches the grant) SHALL pulse for one cycle; the last-served pointer SHALL be updated and the next state SHALL be IDLE.
REQ-019 gnt0/gnt1 SHALL be asserted from LOAD through DONE inclusive, never both at once, and 0 in IDLE.
REQ-020 Request and operand inputs SHALL be ignored outside IDLE; latched operands SHALL NOT change mid-operation.
REQ-021 cnt_load and cnt_enable SHALL never be asserted in the same cycle; outside LOAD, cnt_freshdata SHALL be 0.
REQ-022 A request still held in DONE SHALL be arbitrated afresh in the following IDLE cycle, so there is at least one IDLE cycle between operations.

Reset
REQ-023 While reset = 1 at a clock edge, the state SHALL become IDLE, the last-served pointer SHALL become requester 1, and the latched operands SHALL become 0.
REQ-024 After reset, all outputs SHALL be 0: gnt*, done*, busy, cnt_load, cnt_enable and cnt_freshdata.
REQ-025 Reset asserted mid-operation SHALL abort with no done pulse, and reset SHALL take priority over every other event.

Configuration
REQ-026 With macro COUNTER_ARBITER_ABORT_EN defined, deassertion of the granted request during LOAD or COUNT SHALL return the block to IDLE on the next edge, with no done pulse, cnt_enable forced to 0, and the last-served pointer updated.
REQ-027 Without COUNTER_ARBITER_ABORT_EN, request deassertion after the grant SHALL be ignored and the operation SHALL run to DONE.

Verification
REQ-028 req0=1, start0=3, end0=7 -> gnt0 high for LOAD+COUNT+DONE; cnt_load high for 1 cycle with cnt_freshdata=3; cnt_enable high for exactly 4 cycles; single done0 pulse once cnt_q=7.
REQ-029 req0=req1=1 held continuously from reset -> grants alternate 0,1,0,1; gnt0 and gnt1 are never simultaneous.
REQ-030 start1=14, end1=2 -> cnt_q sequence 14,15,0,1,2; 4 enabled cycles; done1 pulses.
REQ-031 start0=end0=5 -> cnt_enable never asserted; done0 pulses 2 cycles after LOAD.
REQ-032 reset pulsed while in COUNT at cnt_q=5 -> next cycle all outputs 0, no done pulse, state IDLE.
REQ-033 With COUNTER_ARBITER_ABORT_EN defined, req0 dropped mid-COUNT -> IDLE next cycle with no done0; without the macro, done0 still pulses at end0.
